// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared CRC-8 (x^8+x^2+x+1) widths, generator and FSM state type
//
// Purpose: common definitions for the CRC-8 encoder and checker.
//   DATA_W / CRC_W / CW_W : data, CRC and codeword widths
//   POLY                  : generator polynomial without the implicit x^8 term
//   CNT_W                 : width of the bit counter (holds CW_W-1)
//   state_t               : checker FSM states
package crc_pkg;

  localparam int DATA_W = 10;
  localparam int CRC_W  = 8;
  localparam int CW_W   = 18;
  localparam int CNT_W  = 5;

  localparam logic [CRC_W-1:0] POLY = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/crc_lfsr_step.sv
// rtl/crc_lfsr_step.sv - one MSB-first bit of CRC polynomial division
//
// Purpose: combinational single-bit division step, shared by encoder and checker.
// Ports:
//   rem      in  [CRC_W-1:0]  current remainder
//   in_bit   in  1            next codeword bit (MSB-first order)
//   rem_next out [CRC_W-1:0]  remainder after absorbing in_bit
module crc_lfsr_step
  import crc_pkg::*;
(
  input  logic [CRC_W-1:0] rem,
  input  logic             in_bit,
  output logic [CRC_W-1:0] rem_next
);

  // The bit leaving the top of the remainder decides whether the generator
  // is subtracted (XORed) from the shifted value.
  assign rem_next = {rem[CRC_W-2:0], in_bit} ^ (rem[CRC_W-1] ? POLY : '0);

endmodule

// File: rtl/crc_check_lfsr.sv
// rtl/crc_check_lfsr.sv - bit-serial CRC-8 codeword checker with valid/ready handshakes
//
// Purpose: accepts an 18-bit codeword {data[9:0], crc[7:0]}, divides it by
// x^8+x^2+x+1 one bit per cycle (MSB first) and reports the syndrome.
// Ports:
//   clk          in   1   sole clock
//   reset        in   1   synchronous, active-high
//   in_valid     in   1   codeword_in holds a codeword
//   in_ready     out  1   block accepts a codeword this cycle (IDLE only)
//   codeword_in  in   18  {data, crc}, bit 17 transmitted first
//   out_valid    out  1   data_out / syndrome / crc_ok valid
//   out_ready    in   1   consumer accepts the result
//   data_out     out  10  data field of the checked codeword
//   syndrome     out  8   remainder of codeword / generator
//   crc_ok       out  1   syndrome == 0
//   err_count    out  16  results delivered with crc_ok = 0, saturating
module crc_check_lfsr
  import crc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   codeword_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [CRC_W-1:0]  syndrome,
  output logic              crc_ok,
  output logic [15:0]       err_count
);

  state_t              state;
  logic [CW_W-1:0]     shift_reg;
  logic [DATA_W-1:0]   data_reg;
  logic [CRC_W-1:0]    rem;
  logic [CRC_W-1:0]    rem_next;
  logic [CNT_W-1:0]    cnt;

  crc_lfsr_step u_step (
    .rem      (rem),
    .in_bit   (shift_reg[CW_W-1]),
    .rem_next (rem_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      data_reg  <= '0;
      rem       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      data_out  <= '0;
      syndrome  <= '0;
      crc_ok    <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            shift_reg <= codeword_in;
            data_reg  <= codeword_in[CW_W-1:CRC_W];
            rem       <= '0;
            cnt       <= CNT_W'(CW_W - 1);
            in_ready  <= 1'b0;
            state     <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          shift_reg <= {shift_reg[CW_W-2:0], 1'b0};
          rem       <= rem_next;
          if (cnt == '0) begin
            // Last bit: publish the result straight from the step output so
            // out_valid rises on the same edge the FSM enters DONE.
            state     <= ST_DONE;
            out_valid <= 1'b1;
            syndrome  <= rem_next;
            crc_ok    <= (rem_next == '0);
            data_out  <= data_reg;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            if (!crc_ok && (err_count != 16'hFFFF)) begin
              err_count <= err_count + 16'd1;
            end
          end
        end

        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_check_lfsr.sv
// tb/tb_crc_check_lfsr.sv - directed self-checking bench for crc_check_lfsr
module tb_crc_check_lfsr;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] codeword_in;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  data_out;
  logic [7:0]  syndrome;
  logic        crc_ok;
  logic [15:0] err_count;

  int checks   = 0;
  int failures = 0;

  crc_check_lfsr dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .codeword_in (codeword_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_out    (data_out),
    .syndrome    (syndrome),
    .crc_ok      (crc_ok),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  // Present a codeword and return at the falling edge after the accept edge.
  task automatic accept(input logic [17:0] cw);
    int n;
    n = 0;
    @(negedge clk);
    in_valid    = 1'b1;
    codeword_in = cw;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // k = index of the rising edge after accept that first samples out_valid=1.
  task automatic wait_valid(output int k);
    k = 1;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (err_count !== 16'h0) begin failures++; $display("FAIL reset_err_count got=%h exp=0000", err_count); end
    checks++; if (syndrome !== 8'h00) begin failures++; $display("FAIL reset_syndrome got=%h exp=00", syndrome); end
    checks++; if (crc_ok !== 1'b0 || data_out !== 10'h0) begin failures++; $display("FAIL reset_data got=%h/%0b exp=000/0", data_out, crc_ok); end
  endtask

  task automatic test_clean();
    int k;
    accept(18'h30336);
    wait_valid(k);
    checks++; if (k != 19) begin failures++; $display("FAIL clean_latency got=%0d exp=19", k); end
    checks++; if (syndrome !== 8'h00) begin failures++; $display("FAIL clean_syndrome got=%h exp=00", syndrome); end
    checks++; if (crc_ok !== 1'b1) begin failures++; $display("FAIL clean_crc_ok got=%0b exp=1", crc_ok); end
    checks++; if (data_out !== 10'h303) begin failures++; $display("FAIL clean_data got=%h exp=303", data_out); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL clean_in_ready_done got=%0b exp=0", in_ready); end
    handshake();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL clean_after_hs got=ov%0b/ir%0b exp=ov0/ir1", out_valid, in_ready); end
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL clean_err_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_single_bit();
    logic [17:0] cw_tab  [2] = '{18'h30337, 18'h30236};
    logic [7:0]  syn_tab [2] = '{8'h01, 8'h07};
    logic [15:0] err_tab [2] = '{16'd1, 16'd2};
    int k;
    for (int i = 0; i < 2; i++) begin
      accept(cw_tab[i]);
      wait_valid(k);
      checks++; if (k != 19) begin failures++; $display("FAIL err%0d_latency got=%0d exp=19", i, k); end
      checks++; if (syndrome !== syn_tab[i]) begin failures++; $display("FAIL err%0d_syndrome got=%h exp=%h", i, syndrome, syn_tab[i]); end
      checks++; if (crc_ok !== 1'b0) begin failures++; $display("FAIL err%0d_crc_ok got=%0b exp=0", i, crc_ok); end
      checks++; if (data_out !== cw_tab[i][17:8]) begin failures++; $display("FAIL err%0d_data got=%h exp=%h", i, data_out, cw_tab[i][17:8]); end
      handshake();
      checks++; if (err_count !== err_tab[i]) begin failures++; $display("FAIL err%0d_err_count got=%0d exp=%0d", i, err_count, err_tab[i]); end
    end
  endtask

  task automatic test_backpressure();
    int k;
    logic stable;
    accept(18'h30337);
    wait_valid(k);
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) begin
        in_valid    = 1'b1;
        codeword_in = 18'h30336;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || syndrome !== 8'h01 ||
          crc_ok !== 1'b0 || data_out !== 10'h303 || err_count !== 16'd2)
        stable = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (stable !== 1'b1) begin failures++; $display("FAIL bp_stable got=%0b exp=1", stable); end
    checks++; if (out_valid !== 1'b1 || syndrome !== 8'h01) begin failures++; $display("FAIL bp_after_pulse got=ov%0b/%h exp=ov1/01", out_valid, syndrome); end
    handshake();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=ir%0b/ov%0b exp=ir1/ov0", in_ready, out_valid); end
    checks++; if (err_count !== 16'd3) begin failures++; $display("FAIL bp_err_count got=%0d exp=3", err_count); end
    repeat (25) @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_count !== 16'd3) begin failures++; $display("FAIL bp_single_hs got=ov%0b/ir%0b/%0d exp=ov0/ir1/3", out_valid, in_ready, err_count); end
  endtask

  task automatic test_mid_reset();
    int k;
    logic seen;
    accept(18'h30337);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_reset_no_valid got=%0b exp=0", seen); end
    checks++; if (err_count !== 16'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_state got=%0d/ir%0b exp=0/ir1", err_count, in_ready); end
    accept(18'h30336);
    wait_valid(k);
    checks++; if (k != 19 || crc_ok !== 1'b1 || syndrome !== 8'h00) begin failures++; $display("FAIL mid_reset_clean got=%0d/%0b/%h exp=19/1/00", k, crc_ok, syndrome); end
    handshake();
  endtask

  task automatic test_back_to_back();
    int k;
    out_ready = 1'b1;
    accept(18'h30236);
    k = 1;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k != 19) begin failures++; $display("FAIL b2b_latency got=%0d exp=19", k); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_immediate_hs got=ov%0b/ir%0b exp=ov0/ir1", out_valid, in_ready); end
    checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL b2b_err_count got=%0d exp=1", err_count); end
    out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    int k;
    @(negedge clk);
    force dut.err_count = 16'hFFFE;
    @(negedge clk);
    release dut.err_count;
    @(negedge clk);
    checks++; if (err_count !== 16'hFFFE) begin failures++; $display("FAIL sat_preload got=%h exp=fffe", err_count); end
    for (int i = 0; i < 2; i++) begin
      accept(18'h30337);
      wait_valid(k);
      handshake();
      checks++; if (err_count !== 16'hFFFF) begin failures++; $display("FAIL sat_hold%0d got=%h exp=ffff", i, err_count); end
    end
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    codeword_in = '0;
    test_reset();
    test_clean();
    test_single_bit();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
